// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock through a single full adder.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and may be held in DONE for back-to-back operations.

// Single-bit full adder, the only arithmetic element in the datapath.
module sum_1_bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  // Holds the WIDTH-1 result bits already produced; the last bit comes
  // straight from the adder on the final edge.
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;

  logic load, shift, last;
  logic fa_s, fa_cout;

  sum_1_bit u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  assign res_next = {fa_s, res_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus Moore outputs and datapath enables.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shift registers, carry flop, bit counter and partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (shift) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= fa_cout;
      res_q   <= res_next[WIDTH-1:1];
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Visible result only changes on the final RUN edge, so partial sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last) begin
      sum  <= res_next;
      cout <= fa_cout;
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 SHALL have port a  input  WIDTH  first operand; sampled when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second operand; sampled when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; sampled when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result; held until the next accepted start.
REQ-011 SHALL have port cout  output  1  registered final carry-out; held with sum.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), bit-serially.
REQ-013 SHALL instantiate exactly one sum_1_bit (ports A, B, Cin, S, Cout) as the only adder logic; no WIDTH-bit adder allowed.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL accept start in IDLE or DONE: load a, b into internal operand shift registers, load the carry flop from cin, clear the bit counter, enter RUN.
REQ-016 SHALL ignore start while in RUN; the operands and the computation in progress stay unaffected.
REQ-017 SHALL process, in RUN, one bit per cycle, LSB first: the adder sees the LSBs of both operand registers and the carry flop.
REQ-018 SHALL, on each RUN edge, shift both operand registers right by one, shift S into the MSB of the result shift register, and store Cout in the carry flop.
REQ-019 SHALL count bits 0..WIDTH-1 in RUN; on the edge that processes bit WIDTH-1, enter DONE and load cout from the adder Cout.
REQ-020 SHALL have a fixed latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH.
REQ-021 SHALL assert done only in DONE, for exactly one cycle; DONE goes to IDLE unless start=1, which goes to RUN.
REQ-022 SHALL drive busy=1 exactly while in RUN.
REQ-023 SHALL update sum/cout only on the final RUN edge; intermediate shift contents stay internal and are not visible on sum.
REQ-024 SHALL produce correct results for back-to-back operations (start held high in DONE) with no idle cycle required.

Reset
REQ-025 SHALL, on rst_n=0 and independent of clk: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, operand registers=0.
REQ-026 SHALL abort an operation in progress when reset is asserted mid-RUN: no done pulse, sum/cout=0.
REQ-027 SHALL leave IDLE no earlier than the first rising edge with rst_n=1 and start=1.

Verification (WIDTH=8)
REQ-028 SHALL cover: a=0x5A, b=0x3C, cin=0, start at edge k -> busy high for 8 cycles, done pulse after edge k+8, sum=0x96, cout=0.
REQ-029 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-030 SHALL cover: start with a=0x01, b=0x01, then start pulsed again at edge k+3 with a=0xF0 -> ignored; result sum=0x02, cout=0.
REQ-031 SHALL cover: start held high continuously with operands changed each done -> one done every 9 cycles, each result matches a+b+cin.
REQ-032 SHALL cover: rst_n low at edge k+4 mid-RUN -> busy, done, sum, cout immediately 0; no done pulse follows.
REQ-033 SHALL cover: exhaustive a, b in 0..255 with cin in {0,1} against the reference model a+b+cin -> zero mismatches.
